// File: rtl/contador_pkg.sv
// Shared types and constants for the control_contador step-counter sequencer.
// SEQ_CUSTOM_EN selects the custom 8-state count sequence and its reset value.
package contador_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

`ifdef SEQ_CUSTOM_EN
  localparam logic [3:0] Q_RESET = 4'd10;

  // Successor of every 4-bit value; values outside the cycle restart it at 10.
  localparam logic [3:0] SEQ_NEXT [16] = '{
    4'd10, 4'd3,  4'd1,  4'd6,  4'd12, 4'd10, 4'd10, 4'd10,
    4'd10, 4'd2,  4'd4,  4'd10, 4'd9,  4'd10, 4'd10, 4'd10
  };
`endif

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Round-robin: the requester that was not served last has priority.
  function automatic logic pick_winner(input logic ult, input logic [1:0] req);
    if (req[~ult]) return ~ult;
    return ult;
  endfunction

endpackage

// File: rtl/control_contador_if.sv
// Request/grant bus between the requesting logic and the counter sequencer.
interface control_contador_if #(parameter int W = 4);

  logic [1:0]     req;
  logic [2*W-1:0] ini;
  logic [7:0]     pasos;
  logic [1:0]     gnt;
  logic [1:0]     done;
  logic           busy;
  logic [W-1:0]   Q;

  modport master (output req, ini, pasos, input gnt, done, busy, Q);
  modport slave  (input req, ini, pasos, output gnt, done, busy, Q);

endinterface

// File: rtl/sig_contador.sv
// Combinational next-value function of the step counter.
// With SEQ_CUSTOM_EN defined it follows the fixed custom sequence (W must be 4).
module sig_contador
  import contador_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] q,
  output logic [W-1:0] nxt
);

`ifdef SEQ_CUSTOM_EN
  assign nxt = SEQ_NEXT[q];
`else
  assign nxt = q + W'(1);
`endif

endmodule

// File: rtl/control_contador.sv
// Two-way round-robin sequencer that loads and steps the 4-bit counter on negedge C.
// SEQ_CUSTOM_EN switches the counter to the custom sequence with reset value 10.
module control_contador
  import contador_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               C,
  input  logic               nR,
  control_contador_if.slave  bus
);

  state_t       state, state_nx;
  logic         g, ult, win, req_g;
  logic [3:0]   rem, pasos_g;
  logic [W-1:0] q, q_nx, ini_g;

  assign req_g   = bus.req[g];
  assign ini_g   = g ? bus.ini[2*W-1:W] : bus.ini[W-1:0];
  assign pasos_g = g ? bus.pasos[7:4] : bus.pasos[3:0];
  assign win     = pick_winner(ult, bus.req);

  sig_contador #(.W(W)) u_sig (
    .q   (q),
    .nxt (q_nx)
  );

  always_ff @(negedge C or negedge nR) begin
    if (!nR) state <= IDLE;
    else     state <= state_nx;
  end

  // A dropped request in LOAD or RUN aborts straight back to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (|bus.req) state_nx = LOAD;
      LOAD: begin
        if (!req_g)              state_nx = IDLE;
        else if (pasos_g == 4'd0) state_nx = DONE;
        else                     state_nx = RUN;
      end
      RUN: begin
        if (!req_g)           state_nx = IDLE;
        else if (rem == 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(negedge C or negedge nR) begin
    if (!nR) begin
      g   <= 1'b0;
      ult <= 1'b1;
      rem <= 4'd0;
`ifdef SEQ_CUSTOM_EN
      q   <= Q_RESET;
`else
      q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|bus.req) g <= win;
        LOAD: begin
          if (!req_g) ult <= g;
          else begin
            q   <= ini_g;
            rem <= pasos_g;
          end
        end
        RUN: begin
          if (!req_g) ult <= g;
          else begin
            q   <= q_nx;
            rem <= rem - 4'd1;
          end
        end
        DONE:    ult <= g;
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.gnt  = (state != IDLE) ? onehot(g) : 2'b00;
  assign bus.done = (state == DONE) ? onehot(g) : 2'b00;
  assign bus.Q    = q;

endmodule

// File: tb/tb_control_contador.sv
// Self-checking bench for control_contador: vector table, corner sequences, random jobs.
// Builds with or without SEQ_CUSTOM_EN; the reference model follows the same macro.
module tb_control_contador;

  localparam int W = 4;

  logic C = 1'b1;
  logic nR = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lastServed = 1;

`ifdef SEQ_CUSTOM_EN
  localparam logic [3:0] RST_Q = 4'd10;
`else
  localparam logic [3:0] RST_Q = 4'd0;
`endif

  control_contador_if #(.W(W)) bus();

  control_contador #(.W(W)) dut (
    .C   (C),
    .nR  (nR),
    .bus (bus)
  );

  always #5 C = ~C;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Counter value after k steps from start, derived from the stated sequence rules.
  function automatic logic [3:0] refAfter(input logic [3:0] start, input int k);
`ifdef SEQ_CUSTOM_EN
    int ord [8] = '{10, 4, 12, 9, 2, 1, 3, 6};
    int p = -1;
    for (int i = 0; i < 8; i++) if (ord[i] == int'(start)) p = i;
    if (k == 0) return start;
    if (p < 0)  return 4'(ord[(k - 1) % 8]);
    return 4'(ord[(p + k) % 8]);
`else
    return 4'((int'(start) + k) % 16);
`endif
  endfunction

  task automatic tick();
    @(negedge C);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [3:0] i0, input logic [3:0] i1,
                               input logic [3:0] p0, input logic [3:0] p1);
    bus.req   = r;
    bus.ini   = {i1, i0};
    bus.pasos = {p1, p0};
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] g, input logic [1:0] d,
                          input logic b, input logic [3:0] q);
    checkOutput({tag, "_gnt"},  8'(bus.gnt),  8'(g));
    checkOutput({tag, "_done"}, 8'(bus.done), 8'(d));
    checkOutput({tag, "_busy"}, 8'(bus.busy), 8'(b));
    checkOutput({tag, "_q"},    8'(bus.Q),    8'(q));
  endtask

  task automatic pulseReset();
    nR = 1'b0;
    #1;
    nR = 1'b1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] ini0;
    logic [3:0] pasos0;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] q;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{2'b01, 4'd14, 4'd3, 2'b01, 2'b00, 1'b1, RST_Q};
    tbl[1] = '{2'b01, 4'd14, 4'd3, 2'b01, 2'b00, 1'b1, refAfter(4'd14, 0)};
    tbl[2] = '{2'b01, 4'd14, 4'd3, 2'b01, 2'b00, 1'b1, refAfter(4'd14, 1)};
    tbl[3] = '{2'b01, 4'd14, 4'd3, 2'b01, 2'b00, 1'b1, refAfter(4'd14, 2)};
    tbl[4] = '{2'b01, 4'd14, 4'd3, 2'b01, 2'b01, 1'b1, refAfter(4'd14, 3)};
    tbl[5] = '{2'b00, 4'd14, 4'd3, 2'b00, 2'b00, 1'b0, refAfter(4'd14, 3)};
    tbl[6] = '{2'b00, 4'd14, 4'd3, 2'b00, 2'b00, 1'b0, refAfter(4'd14, 3)};

    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    #1;
    checkAll("reset", 2'b00, 2'b00, 1'b0, RST_Q);
    tick();
    nR = 1'b1;

    // Single binary job, one table row per falling edge.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].req, tbl[i].ini0, 4'd0, tbl[i].pasos0, 4'd0);
      tick();
      checkAll($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].q);
    end

    // Reset in the middle of a RUN phase.
    applyStimulus(2'b10, 4'd0, 4'd3, 4'd0, 4'd5);
    tick();
    tick();
    tick();
    checkOutput("midjob_busy_before", 8'(bus.busy), 8'd1);
    nR = 1'b0;
    #1;
    checkAll("midjob_rst", 2'b00, 2'b00, 1'b0, RST_Q);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    nR = 1'b1;
    applyStimulus(2'b01, 4'd5, 4'd0, 4'd0, 4'd0);
    tick();
    checkAll("postrst_gnt", 2'b01, 2'b00, 1'b1, RST_Q);
    tick();
    checkAll("zero_steps", 2'b01, 2'b01, 1'b1, 4'd5);
    applyStimulus(2'b00, 4'd5, 4'd0, 4'd0, 4'd0);
    tick();
    checkAll("zero_idle", 2'b00, 2'b00, 1'b0, 4'd5);

    // Contention with both requests held high.
    pulseReset();
    applyStimulus(2'b11, 4'd2, 4'd7, 4'd2, 4'd0);
    tick();
    checkAll("cont_g0", 2'b01, 2'b00, 1'b1, RST_Q);
    tick();
    checkAll("cont_load0", 2'b01, 2'b00, 1'b1, 4'd2);
    tick();
    checkAll("cont_step0", 2'b01, 2'b00, 1'b1, refAfter(4'd2, 1));
    tick();
    checkAll("cont_done0", 2'b01, 2'b01, 1'b1, refAfter(4'd2, 2));
    tick();
    checkAll("cont_idle0", 2'b00, 2'b00, 1'b0, refAfter(4'd2, 2));
    tick();
    checkAll("cont_g1", 2'b10, 2'b00, 1'b1, refAfter(4'd2, 2));
    tick();
    checkAll("cont_done1", 2'b10, 2'b10, 1'b1, 4'd7);
    tick();
    checkAll("cont_idle1", 2'b00, 2'b00, 1'b0, 4'd7);
    tick();
    checkAll("cont_g0b", 2'b01, 2'b00, 1'b1, 4'd7);
    applyStimulus(2'b00, 4'd2, 4'd7, 4'd2, 4'd0);
    tick();
    checkAll("load_abort", 2'b00, 2'b00, 1'b0, 4'd7);

    // Abort in RUN after two steps, with requester 0 waiting.
    applyStimulus(2'b10, 4'd0, 4'd1, 4'd0, 4'd8);
    tick();
    checkOutput("abort_gnt", 8'(bus.gnt), 8'h02);
    tick();
    tick();
    tick();
    checkOutput("abort_step2", 8'(bus.Q), 8'(refAfter(4'd1, 2)));
    applyStimulus(2'b01, 4'd0, 4'd1, 4'd0, 4'd8);
    tick();
    checkAll("run_abort", 2'b00, 2'b00, 1'b0, refAfter(4'd1, 2));
    tick();
    checkAll("pending_g0", 2'b01, 2'b00, 1'b1, refAfter(4'd1, 2));
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    checkOutput("pending_drop", 8'(bus.busy), 8'd0);

`ifdef SEQ_CUSTOM_EN
    // Full custom cycle and an off-sequence start value.
    applyStimulus(2'b01, 4'd10, 4'd0, 4'd8, 4'd0);
    tick();
    tick();
    checkOutput("seq_load", 8'(bus.Q), 8'd10);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("seq_step%0d", k), 8'(bus.Q), 8'(refAfter(4'd10, k)));
    end
    checkOutput("seq_done", 8'(bus.done), 8'h01);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    applyStimulus(2'b01, 4'd5, 4'd0, 4'd1, 4'd0);
    tick();
    tick();
    tick();
    checkAll("seq_offseq", 2'b01, 2'b01, 1'b1, 4'd10);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
`endif

    // Random jobs checked against a job-level round-robin model.
    pulseReset();
    lastServed = 1;
    for (int j = 0; j < 40; j++) begin
      logic [1:0] mask;
      logic [3:0] i0, i1, p0, p1, startv;
      int         w, n, cnt;
      mask = 2'($urandom_range(1, 3));
      i0 = 4'($urandom);
      i1 = 4'($urandom);
      p0 = 4'($urandom);
      p1 = 4'($urandom);
      if (mask == 2'b11) w = 1 - lastServed;
      else               w = (mask == 2'b10) ? 1 : 0;
      startv = (w == 1) ? i1 : i0;
      n      = (w == 1) ? int'(p1) : int'(p0);
      applyStimulus(mask, i0, i1, p0, p1);
      tick();
      checkOutput("rnd_gnt", 8'(bus.gnt), (w == 1) ? 8'h02 : 8'h01);
      tick();
      checkOutput("rnd_load", 8'(bus.Q), 8'(startv));
      applyStimulus(mask, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      cnt = 0;
      while (bus.done == 2'b00 && cnt < 20) begin
        tick();
        cnt++;
      end
      checkOutput("rnd_len", 8'(cnt), 8'(n));
      checkOutput("rnd_done", 8'(bus.done), (w == 1) ? 8'h02 : 8'h01);
      checkOutput("rnd_q", 8'(bus.Q), 8'(refAfter(startv, n)));
      applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
      tick();
      checkOutput("rnd_idle", 8'(bus.busy), 8'd0);
      lastServed = w;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
